// File: rtl/alu_arbiter_if.sv
//------------------------------------------------------------------------------
// Module   : alu_arbiter_if
// Function : Request/response bundle between two ALU requesters, the response
//            consumer and the alu_arbiter block.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface alu_arbiter_if;
    logic       req0_valid;
    logic       req0_ready;
    logic [7:0] req0_a;
    logic [7:0] req0_b;
    logic [2:0] req0_sel;

    logic       req1_valid;
    logic       req1_ready;
    logic [7:0] req1_a;
    logic [7:0] req1_b;
    logic [2:0] req1_sel;

    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_id;
    logic [7:0] rsp_result;
    logic       rsp_carry;

    logic       busy;

    // Environment side: issues requests and consumes responses
    modport master (
        output req0_valid, req0_a, req0_b, req0_sel,
        output req1_valid, req1_a, req1_b, req1_sel,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_result, rsp_carry, busy
    );

    // Arbiter side
    modport slave (
        input  req0_valid, req0_a, req0_b, req0_sel,
        input  req1_valid, req1_a, req1_b, req1_sel,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_result, rsp_carry, busy
    );
endinterface

`default_nettype wire

// File: rtl/alu_arbiter.sv
//------------------------------------------------------------------------------
// Module   : alu_arbiter (with alu_8bit)
// Function : Shares one 8-bit ALU between two valid/ready requesters. An
//            IDLE/EXEC/RESP FSM latches the granted operands, holds EXEC for
//            EXEC_CYCLES cycles and presents the result until consumed.
//            Optional macro ALU_ARBITER_FIXED_PRIO_EN: requester 0 always
//            wins and the round-robin pointer is removed.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [2:0] sel,
    output logic [7:0] result,
    output logic       carry
);
    logic [8:0] w_wide;

    // Ninth bit carries the carry (ADD/INC) or the borrow (SUB)
    always_comb begin
        w_wide = 9'd0;
        case (sel)
            3'b000:  w_wide = {1'b0, a} + {1'b0, b};
            3'b001:  w_wide = {1'b0, a} - {1'b0, b};
            3'b010:  w_wide = {1'b0, a & b};
            3'b011:  w_wide = {1'b0, a | b};
            3'b100:  w_wide = {1'b0, a ^ b};
            3'b101:  w_wide = {1'b0, ~a};
            3'b110:  w_wide = {1'b0, a} + 9'd1;
            default: w_wide = 9'd0;
        endcase
        result = w_wide[7:0];
        carry  = w_wide[8];
    end
endmodule

module alu_arbiter #(
    parameter int EXEC_CYCLES = 1
) (
    input  logic         clk,
    input  logic         rst,
    alu_arbiter_if.slave bus
);
    localparam logic [1:0] C_IDLE     = 2'd0;
    localparam logic [1:0] C_EXEC     = 2'd1;
    localparam logic [1:0] C_RESP     = 2'd2;
    localparam logic [1:0] C_CNT_LAST = 2'(EXEC_CYCLES - 1);

    logic [1:0] state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic [2:0] sel_q, sel_d;
    logic       id_q, id_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic       rsp_id_q, rsp_id_d;
    logic [7:0] rsp_result_q, rsp_result_d;
    logic       rsp_carry_q, rsp_carry_d;

    logic       w_grant;
    logic       w_ready0;
    logic       w_ready1;
    logic       w_xfer;
    logic [7:0] w_alu_result;
    logic       w_alu_carry;

`ifndef ALU_ARBITER_FIXED_PRIO_EN
    logic       last_q, last_d;
`endif

    // Operands always come from the latches, never straight from the ports
    alu_8bit u_alu (
        .a      (a_q),
        .b      (b_q),
        .sel    (sel_q),
        .result (w_alu_result),
        .carry  (w_alu_carry)
    );

    // Pick a requester and form the IDLE-only, reset-gated ready strobes
    always_comb begin
`ifdef ALU_ARBITER_FIXED_PRIO_EN
        w_grant = !bus.req0_valid;
`else
        if (bus.req0_valid && bus.req1_valid) begin
            w_grant = ~last_q;
        end else if (bus.req0_valid) begin
            w_grant = 1'b0;
        end else begin
            w_grant = 1'b1;
        end
`endif
        w_ready0 = (state_q == C_IDLE) && !rst && !w_grant && bus.req0_valid;
        w_ready1 = (state_q == C_IDLE) && !rst &&  w_grant && bus.req1_valid;
        w_xfer   = w_ready0 || w_ready1;
    end

    // FSM next state, operand capture and response capture
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        a_d          = a_q;
        b_d          = b_q;
        sel_d        = sel_q;
        id_d         = id_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_carry_d  = rsp_carry_q;
        case (state_q)
            C_IDLE: begin
                if (w_xfer) begin
                    state_d = C_EXEC;
                    cnt_d   = 2'd0;
                    a_d     = w_grant ? bus.req1_a   : bus.req0_a;
                    b_d     = w_grant ? bus.req1_b   : bus.req0_b;
                    sel_d   = w_grant ? bus.req1_sel : bus.req0_sel;
                    id_d    = w_grant;
                end
            end
            C_EXEC: begin
                if (cnt_q == C_CNT_LAST) begin
                    state_d      = C_RESP;
                    cnt_d        = 2'd0;
                    rsp_valid_d  = 1'b1;
                    rsp_id_d     = id_q;
                    rsp_result_d = w_alu_result;
                    rsp_carry_d  = w_alu_carry;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            C_RESP: begin
                if (bus.rsp_ready) begin
                    state_d     = C_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = C_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any operation in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= C_IDLE;
            cnt_q        <= 2'd0;
            a_q          <= 8'd0;
            b_q          <= 8'd0;
            sel_q        <= 3'd0;
            id_q         <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= 8'd0;
            rsp_carry_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            a_q          <= a_d;
            b_q          <= b_d;
            sel_q        <= sel_d;
            id_q         <= id_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_carry_q  <= rsp_carry_d;
        end
    end

`ifndef ALU_ARBITER_FIXED_PRIO_EN
    // Last-grant pointer moves only on a transfer; starts at 1 so requester 0 wins first
    always_comb begin
        last_d = w_xfer ? w_grant : last_q;
    end

    // Last-grant pointer register
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    assign bus.req0_ready = w_ready0;
    assign bus.req1_ready = w_ready1;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_carry  = rsp_carry_q;
    assign bus.busy       = (state_q != C_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_alu_arbiter
// Function : Directed self-checking bench for alu_arbiter (EXEC_CYCLES=1 and 4).
//            Honours ALU_ARBITER_FIXED_PRIO_EN for the expected grant order.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_arbiter;
    logic clk;
    logic rst;
    int   tests;
    int   fails;

    alu_arbiter_if bus ();
    alu_arbiter_if bus4 ();

    alu_arbiter #(.EXEC_CYCLES(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    alu_arbiter #(.EXEC_CYCLES(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [7:0] VA  [9] = '{8'd10, 8'd5,  8'd200, 8'd255, 8'd10,  8'd99, 8'hF0, 8'hF0, 8'hF0};
    localparam logic [7:0] VB  [9] = '{8'd5,  8'd10, 8'd100, 8'd0,   8'd0,   8'd77, 8'h3C, 8'h3C, 8'h3C};
    localparam logic [2:0] VS  [9] = '{3'd1,  3'd1,  3'd0,   3'd6,   3'd5,   3'd7,  3'd2,  3'd3,  3'd4};
    localparam logic [7:0] VR  [9] = '{8'd5,  8'd251,8'd44,  8'd0,   8'd245, 8'd0,  8'h30, 8'hFC, 8'hCC};
    localparam logic       VC  [9] = '{1'b0,  1'b1,  1'b1,   1'b1,   1'b0,   1'b0,  1'b0,  1'b0,  1'b0};

    // Issue one request on the EXEC_CYCLES=1 DUT and return what came back
    task automatic do_op(input logic id, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] sel, output logic [7:0] res, output logic car,
                         output logic rid, output int lat, output logic ok);
        int n;
        ok = 1'b0; lat = 0; res = 8'd0; car = 1'b0; rid = 1'b0;
        @(negedge clk);
        if (!id) begin
            bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_sel = sel;
        end else begin
            bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_sel = sel;
        end
        #1;
        n = 0;
        while (!(id ? bus.req1_ready : bus.req0_ready) && n < 20) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 20) begin
            bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        // Scramble the request lines: the latched operands must not care
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        bus.req0_a = ~a; bus.req0_b = ~b; bus.req0_sel = ~sel;
        bus.req1_a = ~a; bus.req1_b = ~b; bus.req1_sel = ~sel;
        n = 0;
        while (!bus.rsp_valid && n < 20) begin
            @(negedge clk); n++;
        end
        lat = n;
        res = bus.rsp_result;
        car = bus.rsp_carry;
        rid = bus.rsp_id;
        ok  = (n < 20);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        tests++;
        if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
            fails++; $display("FAIL reset_ready: got %b expected 00", {bus.req0_ready, bus.req1_ready});
        end
        tests++;
        if ({bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_carry, bus.busy} !== 12'd0) begin
            fails++; $display("FAIL reset_outputs: got v=%b id=%b r=%0d c=%b busy=%b expected all 0",
                              bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_carry, bus.busy);
        end
        tests++;
        if ({bus4.rsp_valid, bus4.busy} !== 2'b00) begin
            fails++; $display("FAIL reset_dut4: got v=%b busy=%b expected 0 0", bus4.rsp_valid, bus4.busy);
        end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_add;
        logic [7:0] r; logic c; logic id; int lat; logic ok;
        do_op(1'b0, 8'd10, 8'd5, 3'd0, r, c, id, lat, ok);
        tests++;
        if (ok !== 1'b1) begin fails++; $display("FAIL add_timeout: got ok=%b expected 1", ok); end
        tests++;
        if (r !== 8'd15) begin fails++; $display("FAIL add_result: got %0d expected 15", r); end
        tests++;
        if (c !== 1'b0) begin fails++; $display("FAIL add_carry: got %b expected 0", c); end
        tests++;
        if (id !== 1'b0) begin fails++; $display("FAIL add_id: got %b expected 0", id); end
        tests++;
        if (lat != 2) begin fails++; $display("FAIL add_latency: got %0d expected 2", lat); end
    endtask

    task automatic test_alu_ops;
        logic [7:0] r; logic c; logic id; int lat; logic ok;
        for (int i = 0; i < 9; i++) begin
            do_op(1'b1, VA[i], VB[i], VS[i], r, c, id, lat, ok);
            tests++;
            if (ok !== 1'b1 || r !== VR[i] || c !== VC[i] || id !== 1'b1) begin
                fails++;
                $display("FAIL alu_op%0d: got ok=%b r=%0d c=%b id=%b expected ok=1 r=%0d c=%b id=1",
                         i, ok, r, c, id, VR[i], VC[i]);
            end
        end
    endtask

    task automatic test_round_robin;
        int k;
        int gid  [4];
        int gcyc [4];
        int exp_id [4];
`ifdef ALU_ARBITER_FIXED_PRIO_EN
        exp_id = '{0, 0, 0, 0};
`else
        exp_id = '{0, 1, 0, 1};
`endif
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        bus.rsp_ready = 1'b1;
        bus.req0_a = 8'd1; bus.req0_b = 8'd0; bus.req0_sel = 3'd0;
        bus.req1_a = 8'd2; bus.req1_b = 8'd0; bus.req1_sel = 3'd0;
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        k = 0;
        for (int c = 0; c < 60 && k < 4; c++) begin
            #1;
            if (bus.req0_ready) begin gid[k] = 0; gcyc[k] = c; k++; end
            else if (bus.req1_ready) begin gid[k] = 1; gcyc[k] = c; k++; end
            @(negedge clk);
        end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        tests++;
        if (k != 4) begin
            fails++; $display("FAIL rr_grants: got %0d grants expected 4", k);
        end
        for (int i = 0; i < k; i++) begin
            tests++;
            if (gid[i] != exp_id[i]) begin
                fails++; $display("FAIL rr_order%0d: got %0d expected %0d", i, gid[i], exp_id[i]);
            end
        end
        if (k >= 2) begin
            tests++;
            if (gcyc[1] - gcyc[0] != 3) begin
                fails++; $display("FAIL rr_interval: got %0d expected 3", gcyc[1] - gcyc[0]);
            end
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_backpressure;
        logic [7:0] r; logic c; logic id; int lat; logic ok;
        bus.rsp_ready = 1'b0;
        do_op(1'b0, 8'd7, 8'd9, 3'd0, r, c, id, lat, ok);
        tests++;
        if (ok !== 1'b1 || r !== 8'd16) begin
            fails++; $display("FAIL bp_result: got ok=%b r=%0d expected ok=1 r=16", ok, r);
        end
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            tests++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 8'd16 || bus.rsp_id !== 1'b0 ||
                bus.rsp_carry !== 1'b0 || bus.busy !== 1'b1 || bus.req0_ready !== 1'b0 ||
                bus.req1_ready !== 1'b0) begin
                fails++;
                $display("FAIL bp_hold%0d: got v=%b r=%0d id=%b c=%b busy=%b rdy=%b%b expected v=1 r=16 id=0 c=0 busy=1 rdy=00",
                         i, bus.rsp_valid, bus.rsp_result, bus.rsp_id, bus.rsp_carry, bus.busy,
                         bus.req0_ready, bus.req1_ready);
            end
        end
        bus.rsp_ready = 1'b1;
        #1;
        tests++;
        if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
            fails++; $display("FAIL bp_consume_ready: got %b expected 00", {bus.req0_ready, bus.req1_ready});
        end
        @(negedge clk); #1;
        tests++;
        if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin
            fails++; $display("FAIL bp_release: got busy=%b v=%b expected 0 0", bus.busy, bus.rsp_valid);
        end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    endtask

    task automatic test_reset_exec;
        logic [7:0] r; logic c; logic id; int lat; logic ok;
        int n;
        logic seen;
        @(negedge clk);
        bus.req0_valid = 1'b1; bus.req0_a = 8'd3; bus.req0_b = 8'd3; bus.req0_sel = 3'd0;
        #1;
        n = 0;
        while (!bus.req0_ready && n < 20) begin @(negedge clk); #1; n++; end
        tests++;
        if (n >= 20) begin fails++; $display("FAIL rx_grant: got no grant expected grant"); end
        @(negedge clk);
        bus.req0_valid = 1'b0;
        tests++;
        if (bus.busy !== 1'b1) begin fails++; $display("FAIL rx_in_exec: got busy=%b expected 1", bus.busy); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests++;
        if ({bus.busy, bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_carry,
             bus.req0_ready, bus.req1_ready} !== 14'd0) begin
            fails++; $display("FAIL rx_cleared: got busy=%b v=%b id=%b r=%0d c=%b expected all 0",
                              bus.busy, bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_carry);
        end
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) seen = 1'b1;
        end
        tests++;
        if (seen !== 1'b0) begin fails++; $display("FAIL rx_no_resp: got response expected none"); end
        do_op(1'b1, 8'd3, 8'd4, 3'd0, r, c, id, lat, ok);
        tests++;
        if (ok !== 1'b1 || r !== 8'd7 || id !== 1'b1) begin
            fails++; $display("FAIL rx_req1: got ok=%b r=%0d id=%b expected ok=1 r=7 id=1", ok, r, id);
        end
    endtask

    task automatic test_exec4;
        int g0, g1, r0;
        logic [7:0] res4;
        logic id4;
        g0 = -1; g1 = -1; r0 = -1; res4 = 8'd0; id4 = 1'b1;
        @(negedge clk);
        bus4.rsp_ready = 1'b1;
        bus4.req0_a = 8'd1; bus4.req0_b = 8'd2; bus4.req0_sel = 3'd0;
        bus4.req0_valid = 1'b1;
        for (int c = 0; c < 40 && g1 < 0; c++) begin
            #1;
            if (bus4.rsp_valid && r0 < 0 && g0 >= 0) begin
                r0 = c; res4 = bus4.rsp_result; id4 = bus4.rsp_id;
            end
            if (bus4.req0_ready) begin
                if (g0 < 0) g0 = c; else g1 = c;
            end
            @(negedge clk);
        end
        bus4.req0_valid = 1'b0;
        tests++;
        if (g0 < 0 || g1 < 0 || r0 < 0) begin
            fails++; $display("FAIL x4_events: got g0=%0d g1=%0d r0=%0d expected all seen", g0, g1, r0);
        end
        tests++;
        if (r0 - g0 != 5) begin fails++; $display("FAIL x4_latency: got %0d expected 5", r0 - g0); end
        tests++;
        if (g1 - g0 != 6) begin fails++; $display("FAIL x4_interval: got %0d expected 6", g1 - g0); end
        tests++;
        if (res4 !== 8'd3 || id4 !== 1'b0) begin
            fails++; $display("FAIL x4_result: got r=%0d id=%b expected r=3 id=0", res4, id4);
        end
        repeat (8) @(negedge clk);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        bus.req0_valid = 1'b0; bus.req0_a = 8'd0; bus.req0_b = 8'd0; bus.req0_sel = 3'd0;
        bus.req1_valid = 1'b0; bus.req1_a = 8'd0; bus.req1_b = 8'd0; bus.req1_sel = 3'd0;
        bus.rsp_ready = 1'b1;
        bus4.req0_valid = 1'b0; bus4.req0_a = 8'd0; bus4.req0_b = 8'd0; bus4.req0_sel = 3'd0;
        bus4.req1_valid = 1'b0; bus4.req1_a = 8'd0; bus4.req1_b = 8'd0; bus4.req1_sel = 3'd0;
        bus4.rsp_ready = 1'b1;

        test_reset();
        test_add();
        test_alu_ops();
        test_round_robin();
        test_backpressure();
        test_reset_exec();
        test_exec4();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter EXEC_CYCLES, default 1, legal range 1..4: the number of cycles the block spends in state EXEC.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 req0_a / req0_b  input  8 each  requester 0 operands.
REQ-007 req0_sel  input  3  requester 0 opcode.
REQ-008 req1_valid, req1_ready, req1_a, req1_b, req1_sel  same widths and directions as the requester 0 ports, for requester 1.
REQ-009 rsp_valid  output  1  response held for the consumer.
REQ-010 rsp_ready  input  1  consumer accepts the response.
REQ-011 rsp_id  output  1  index of the requester that owns the response.
REQ-012 rsp_result  output  8  ALU result.
REQ-013 rsp_carry  output  1  ALU carry.
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 The block shall share one instance of the existing alu_8bit (ports a, b, sel, result, carry) between two requesters.
REQ-016 Opcode table the block shall honour:
- 000 ADD: {carry,result} = a+b
- 001 SUB: {carry,result} = {0,a}-{0,b}; carry is the borrow
- 010 AND, 011 OR, 100 XOR, 101 NOT a: carry=0
- 110 INC a: {carry,result} = a+1
- 111 CLEAR: result=0, carry=0
REQ-017 The FSM shall have exactly three states: IDLE, EXEC and RESP.
REQ-018 In IDLE, reqN_ready shall be driven combinationally: high only for the granted requester, and only if that requester's valid is high.
REQ-019 A transfer occurs when valid and ready are both high; on that edge the block shall latch a, b, sel and id, and enter EXEC.
REQ-020 The block shall hold EXEC for EXEC_CYCLES cycles, then capture the ALU result and carry into the rsp registers and enter RESP.
REQ-021 In RESP, rsp_valid=1, and rsp_id, rsp_result and rsp_carry shall be stable until rsp_valid && rsp_ready; on that edge the block returns to IDLE.
REQ-022 rsp_valid shall fall in the first IDLE cycle; no new request shall be accepted in the same cycle that a response is consumed.
REQ-023 Latency: with the handshake at edge N, rsp_valid shall be high after edge N+EXEC_CYCLES+1.
REQ-024 Minimum issue interval shall be EXEC_CYCLES+2 cycles.
REQ-025 Round-robin grant: if only one requester is valid, it shall be granted; if both are valid, the requester not granted last shall be granted.
REQ-026 The last-grant pointer shall update only on a transfer.
REQ-027 req*_ready shall be 0 in EXEC and RESP.
REQ-028 Operands are sampled only at the handshake; changes outside the handshake have no effect.
REQ-029 A requester that drops valid before being granted shall lose nothing and cause no error.
REQ-030 The ALU operands shall come only from the latched registers, never directly from the request ports.

Reset
REQ-031 When rst=1 at a clock edge, state shall become IDLE and the last-grant pointer shall become 1, so requester 0 wins first.
REQ-032 On reset, rsp_valid, rsp_id, rsp_result, rsp_carry, busy, the operand latches and the EXEC counter shall become 0.
REQ-033 Reset asserted during EXEC or RESP shall discard the operation in flight; no response shall be emitted for it.
REQ-034 While rst=1, req*_ready shall be 0.

Configuration
REQ-035 Macro ALU_ARBITER_FIXED_PRIO_EN.
REQ-036 When ALU_ARBITER_FIXED_PRIO_EN is defined, requester 0 shall always win over requester 1 and the last-grant pointer shall be absent.
REQ-037 When ALU_ARBITER_FIXED_PRIO_EN is undefined, the round-robin rule of REQ-025 and REQ-026 shall apply.
REQ-038 All other behaviour shall be identical with and without ALU_ARBITER_FIXED_PRIO_EN.

Verification
REQ-039 req0 a=10, b=5, sel=000, rsp_ready=1 -> rsp_result=15, rsp_carry=0, rsp_id=0, rsp_valid 2 cycles after the handshake (EXEC_CYCLES=1).
REQ-040 req1 sequence: SUB 10,5; SUB 5,10; ADD 200,100; INC 255 -> results 5/c0, 251/c1, 44/c1, 0/c1; NOT 10 -> 245/c0; CLEAR -> 0/c0.
REQ-041 Both requesters valid from reset -> grant order 0,1,0,1; with ALU_ARBITER_FIXED_PRIO_EN defined -> grant order 0,0,0.
REQ-042 rsp_ready=0 for 5 cycles in RESP -> rsp outputs stable, req*_ready=0, busy=1; one cycle after rsp_ready=1, busy=0.
REQ-043 rst pulsed during EXEC -> the next cycle is IDLE with all outputs 0 and no response emitted; a subsequent req1 is served first only if req0 is idle.
REQ-044 EXEC_CYCLES=4 -> rsp_valid 5 cycles after the handshake; issue interval of 6 cycles under continuous requests.
